serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder: one full-adder slice, computed as s = a^b^c and cout = ab | c(a^b), plus a registered carry flip-flop.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, over WIDTH clocks.
- It is the sequential stage that feeds operand bits into the full-adder slice and collects the sum bits that slice produces.
- Used where area matters more than latency. Start/done handshake to the controller.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  request; sampled on rising edge, accepted only when busy=0
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry-in, captured on accepted start
- busy  out  1  high while an operation is in progress (RUN or DONE)
- done  out  1  one-cycle pulse; sum/cout valid
- sum  out  WIDTH  result, registered
- cout  out  1  final carry-out, registered

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-low, port rst_n; all state clears immediately on rst_n=0.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry and bit counter are also 0.
- States: IDLE, RUN, DONE. busy=1 in RUN and DONE. done=1 only in DONE.
- IDLE:
  - start=1 at edge E0 loads shA<=a, shB<=b, carry<=cin, cnt<=0, and sets state<=RUN.
  - start=0 holds state.
  - sum/cout hold the last result.
- RUN, each edge:
  - bit = shA[0]^shB[0]^carry.
  - carry <= majority(shA[0], shB[0], carry).
  - shA and shB shift right by 1.
  - sum <= {bit, sum[WIDTH-1:1]}.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th bit), state<=DONE and cout<=new carry.
- DONE: lasts exactly one cycle, then IDLE unconditionally. start during DONE is ignored.
- Latency: start accepted at E0; done high during the cycle following edge E_WIDTH, so the result is valid WIDTH cycles after the accept edge. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Intermediate values:
  - sum contents during RUN are partial and carry no meaning.
  - cout keeps its previous value until the final RUN edge.
- Start handling:
  - start while busy=1 is ignored; no re-capture and no queueing.
  - a, b and cin may change freely after the accept edge with no effect.
- Overflow: an unsigned carry out of the MSB appears only on cout. sum wraps modulo 2^WIDTH.
- Reset mid-operation: the operation is aborted immediately and all outputs return to reset values. No done pulse is generated for the aborted operation.
- Counter width: clog2(WIDTH) bits, minimum 1. cnt never exceeds WIDTH-1.

Test Plan (WIDTH=8):
1. Reset, then start with a=0x00, b=0x00, cin=0 -> busy=1 for 9 cycles; done pulses once 8 cycles after the accept edge; sum=0x00, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0. Results hold in IDLE after done falls.
3. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1 (MSB carry path).
4. Start 0x12+0x34. During RUN, pulse start with a=0xFF, b=0xFF and also change the a/b inputs -> still exactly one done; sum=0x46, cout=0; no second operation starts.
5. Start 0xF0+0x0F. Drive rst_n=0 between clock edges in the 4th RUN cycle -> busy, done, sum and cout go to 0 without waiting for a clock edge. No done pulse follows. A new start after release works normally.
6. Hold start=1 continuously with a=0x01, b=0x01 -> a new operation is accepted only on edges where busy=0. Each done shows sum=0x02, and the gap between done pulses is 10 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, adding two WIDTH-bit
// operands LSB-first over WIDTH clocks with a start/done handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; sum/cout hold the last result
// RUN    | one operand bit pair consumed per clock, sum shifted in MSB-first
// DONE   | one-cycle result-valid pulse, then back to IDLE
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             carry_nxt;

    assign bit_s     = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_nxt = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry <= carry_nxt;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sum   <= {bit_s, sum[WIDTH-1:1]};
                    if (cnt == CNT_LAST) begin
                        // wrap instead of incrementing so cnt stays within 0..WIDTH-1
                        cnt   <= '0;
                        cout  <= carry_nxt;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed plan cases plus randomized
// operations, compared every cycle against a transaction-level model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted start occupies the block for W+1
    // cycles, the last of which presents a+b+cin.
    int           m_left = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic [W-1:0] m_pend_sum = '0;
    logic         m_pend_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 1) begin
                m_sum  = m_pend_sum;
                m_cout = m_pend_cout;
            end
        end else if (start) begin
            {m_pend_cout, m_pend_sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            m_left = W + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
            check("model_done", {31'b0, done}, {31'b0, (m_left == 1)});
            check("model_cout", {31'b0, cout}, {31'b0, m_cout});
            if (!busy || done)
                check("model_sum", {24'b0, sum}, {24'b0, m_sum});
        end
    end

    // One operation from an idle block; optionally pokes start/a/b mid-run.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input bit disturb,
                          input string nm);
        int busy_cnt;
        int done_cnt;
        int done_at;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        @(posedge clk); #2;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            if (k == 0) start = 1'b0;
            if (disturb && k == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
            if (disturb && k == 4) begin start = 1'b0; a = 8'h55; b = 8'hAA; end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
                check({nm, "_sum"}, {24'b0, sum}, {24'b0, es});
                check({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
            end
            if (!busy) break;
        end
        check({nm, "_busy_len"}, busy_cnt, W + 1);
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_latency"}, done_at, W);
        @(posedge clk); #2;
        check({nm, "_idle"}, {31'b0, busy}, 32'd0);
        check({nm, "_hold_sum"}, {24'b0, sum}, {24'b0, es});
    endtask

    initial begin
        int dones[$];
        int gaps_ok;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W:0] rr;

        #13;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_sum", {24'b0, sum}, 32'd0);
        check("reset_cout", {31'b0, cout}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        cmp_en = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
        run_op(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b0, "mix");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "all_ones");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "msb");
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, "ignore_start");

        // abort in the 4th RUN cycle, asserting reset between clock edges
        @(posedge clk); #2;
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_sum", {24'b0, sum}, 32'd0);
        check("abort_cout", {31'b0, cout}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        begin
            int late_done;
            late_done = 0;
            repeat (12) begin
                @(posedge clk); #2;
                if (done) late_done++;
            end
            check("abort_no_done", late_done, 0);
        end
        run_op(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 1'b0, "after_abort");

        // start held high: one accept per W+2 cycles
        @(posedge clk); #2;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #2;
            if (done) begin
                dones.push_back(k);
                check("held_sum", {24'b0, sum}, 32'h02);
            end
        end
        start = 1'b0;
        check("held_done_count", dones.size(), 4);
        gaps_ok = 1;
        for (int i = 1; i < dones.size(); i++)
            if (dones[i] - dones[i-1] != W + 2) gaps_ok = 0;
        check("held_gap", gaps_ok, 1);
        repeat (W + 2) @(posedge clk);
        #2;

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rr = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, rr[W-1:0], rr[W], 1'($urandom_range(0, 1)), "rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
